rowram_writer: RTL
==================

ROWRAM_WRITER -- requirements
Module: rowram_writer

Interface
REQ-001 Parameter ROW_W, default 320: pixels per displayed row.
REQ-002 Parameter NUM_ROWS, default 240: rows per frame.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 pix_valid  in  1  pixel-mixer output pixel valid.
REQ-006 pix_data  in  10  pixel colour/palette index.
REQ-007 pix_ready  out  1  block accepts pix_data this cycle.
REQ-008 row_start  out  1  one-cycle pulse: begin producing row next_row.
REQ-009 next_row  out  8  row index the mixer SHALL produce next.
REQ-010 rowram_rdaddr  in  9  HDMI-side read address.
REQ-011 rowram_rddata  out  10  HDMI-side read data.
REQ-012 rowram_swap  in  1  one-cycle pulse from HDMI side at end of displayed row.
REQ-013 underrun  out  1  sticky: a swap arrived before the fill row was complete.
REQ-014 underrun_cnt  out  8  saturating underrun count (see Configuration).

Function
REQ-015 Two banks of ROW_W x 10 bits; bank_sel selects the display bank, the other bank is the fill bank.
REQ-016 Write FSM states: FILL, FULL; transfer occurs when pix_valid && pix_ready.
REQ-017 FILL: pix_ready=1; each transfer writes pix_data to fill bank at wr_ptr and increments wr_ptr.
REQ-018 FILL -> FULL when the transfer at wr_ptr==ROW_W-1 occurs; FULL: pix_ready=0, no writes.
REQ-019 rowram_swap in FULL: bank_sel toggles, wr_ptr=0, state=FILL, next_row increments, row_start pulses the following cycle.
REQ-020 next_row wraps NUM_ROWS-1 -> 0.
REQ-021 rowram_swap in FILL (underrun): bank_sel unchanged (previous row redisplayed), wr_ptr=0, state FILL, next_row unchanged, underrun set, row_start pulses the following cycle.
REQ-022 Swap coincident with final-pixel transfer: pixel written, row treated as complete, REQ-019 applies.
REQ-023 Read latency exactly 1 cycle: rowram_rddata = display bank[rowram_rdaddr] of the cycle before.
REQ-024 rowram_rdaddr >= ROW_W returns 10'd0.
REQ-025 Read in the swap cycle uses the pre-swap bank_sel.
REQ-026 pix_valid in FULL is ignored; pix_data need not be held stable by this block's contract beyond the transfer cycle.
REQ-027 Writes never target the display bank.

Reset
REQ-028 On rst_n low at posedge clk: state=FILL, wr_ptr=0, bank_sel=0, next_row=0, underrun=0, underrun_cnt=0, rowram_rddata=0.
REQ-029 row_start pulses the first cycle after rst_n deasserts (request row 0).
REQ-030 Bank contents are not reset; reset mid-fill discards the partial row.

Configuration
REQ-031 Macro ROWRAM_UNDERRUN_CNT_EN defined: underrun_cnt increments on each underrun swap, saturating at 255, cleared only by reset.
REQ-032 Macro undefined: underrun_cnt tied to 8'd0, no counter logic; underrun flag unaffected.

Verification
REQ-033 Reset release -> row_start pulse next cycle, next_row=0, pix_ready=1, rowram_rddata=0.
REQ-034 Stream 320 pixels value=i, then swap -> pix_ready=0 after pixel 319; after swap read addr 5 returns 5 one cycle later, next_row=1.
REQ-035 Stream 100 pixels then swap -> underrun=1, bank_sel unchanged, next_row unchanged, wr_ptr restarts at 0 (pixel 101 lands at addr 0).
REQ-036 Swap in same cycle as pixel 319 transfer -> no underrun, banks flip, addr 319 reads written value.
REQ-037 240 complete rows -> next_row wraps 239 -> 0; read addr 400 -> 0.
REQ-038 With ROWRAM_UNDERRUN_CNT_EN, 300 underruns -> underrun_cnt=255; without macro -> 0.

Source files
------------

// File: rtl/rowram_writer.sv
// rtl/rowram_writer.sv - double-buffered row RAM: mixer fills one bank while HDMI reads the other
// Define ROWRAM_UNDERRUN_CNT_EN to build the saturating underrun counter.
module rowram_writer #(
  parameter int ROW_W    = 320,
  parameter int NUM_ROWS = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic [9:0] pix_data,
  output logic       pix_ready,
  output logic       row_start,
  output logic [7:0] next_row,
  input  logic [8:0] rowram_rdaddr,
  output logic [9:0] rowram_rddata,
  input  logic       rowram_swap,
  output logic       underrun,
  output logic [7:0] underrun_cnt
);
  localparam int            AW       = $clog2(ROW_W);
  localparam logic [AW-1:0] LAST_PIX = AW'(ROW_W - 1);
  localparam logic [7:0]    LAST_ROW = 8'(NUM_ROWS - 1);
  localparam logic [9:0]    ROW_LIM  = 10'(ROW_W);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          bank_sel;
  logic          in_reset;
  logic [9:0]    bank0 [ROW_W];
  logic [9:0]    bank1 [ROW_W];

  logic xfer;
  logic last_xfer;
  logic row_done;

  assign xfer      = pix_valid && pix_ready;
  assign last_xfer = xfer && (wr_ptr == LAST_PIX);
  // A swap landing on the final-pixel transfer still counts as a complete row.
  assign row_done  = (state == FULL) || last_xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      pix_ready <= 1'b1;
      wr_ptr    <= '0;
      bank_sel  <= 1'b0;
      next_row  <= '0;
      underrun  <= 1'b0;
      row_start <= 1'b0;
      in_reset  <= 1'b1;
    end else begin
      in_reset  <= 1'b0;
      row_start <= in_reset || rowram_swap;
      if (rowram_swap) begin
        state     <= FILL;
        pix_ready <= 1'b1;
        wr_ptr    <= '0;
        if (row_done) begin
          bank_sel <= ~bank_sel;
          next_row <= (next_row == LAST_ROW) ? 8'd0 : next_row + 8'd1;
        end else begin
          underrun <= 1'b1;
        end
      end else if (xfer) begin
        if (last_xfer) begin
          state     <= FULL;
          pix_ready <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Fill bank is always the one not selected for display.
  always_ff @(posedge clk) begin
    if (rst_n && xfer) begin
      if (bank_sel) bank0[wr_ptr] <= pix_data;
      else          bank1[wr_ptr] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               rowram_rddata <= '0;
    else if ({1'b0, rowram_rdaddr} >= ROW_LIM) rowram_rddata <= '0;
    else if (bank_sel)                        rowram_rddata <= bank1[rowram_rdaddr[AW-1:0]];
    else                                      rowram_rddata <= bank0[rowram_rdaddr[AW-1:0]];
  end

`ifdef ROWRAM_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (rowram_swap && !row_done && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`else
  assign underrun_cnt = 8'd0;
`endif

endmodule
